// File: rtl/clock_set_ui.sv
// Push-button set-mode front end for the time-of-day counter chain.
// Optional auto-repeat of INCR while UP is held: define CLOCK_SET_AUTOREPEAT_EN.
`timescale 1ns/1ps

module clock_set_ui #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 500000000
`ifdef CLOCK_SET_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic       SET_HOUR,
  output logic       SET_MIN,
  output logic       SET_SEC,
  output logic       INCR,
  output logic [1:0] MODE_STATE
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2,
    S_SEC  = 2'd3
  } state_e;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);

  // Zero timeout disables the return; keep a 1-bit counter then.
  localparam int TW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLAST =
    (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  // Index 0 = MODE, index 1 = UP.
  logic [1:0]    btn;
  logic [1:0]    s1_q;
  logic [1:0]    s2_q;
  logic [1:0]    lvl_q;
  logic [1:0]    flip;
  logic [1:0]    rise;
  logic [DW-1:0] cnt_q [2];

  state_e        st_q;
  state_e        st_d;
  logic [TW-1:0] tmo_q;
  logic          mode_ev;
  logic          up_ev;
  logic          in_set;
  logic          tmo_hit;
  logic          rep_tick;
  logic          incr_ev;
  logic          incr_d;

  assign btn = {BTN_UP, BTN_MODE};

  // Level flips once the mismatch has persisted DEBOUNCE_CYCLES counts.
  always_comb begin
    flip = '0;
    rise = '0;
    for (int i = 0; i < 2; i++) begin
      flip[i] = (s2_q[i] != lvl_q[i]) && (cnt_q[i] == DMAX);
      rise[i] = flip[i] & ~lvl_q[i];
    end
  end

  // Two-flop synchroniser plus stability counter per button.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (flip[i]) begin
          lvl_q[i] <= ~lvl_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign mode_ev = rise[0];
  assign up_ev   = rise[1];
  assign in_set  = (st_q != RUN);
  assign tmo_hit = TMO_EN && (tmo_q == TLAST);
  assign incr_ev = in_set & (up_ev | rep_tick);
  assign incr_d  = incr_ev & ~mode_ev;

  // MODE beats everything; an increment beats the timeout.
  always_comb begin
    st_d = st_q;
    if (mode_ev) begin
      unique case (st_q)
        RUN:     st_d = S_HOUR;
        S_HOUR:  st_d = S_MIN;
        S_MIN:   st_d = S_SEC;
        default: st_d = RUN;
      endcase
    end else if (in_set && !incr_ev && tmo_hit) begin
      st_d = RUN;
    end
  end

  // State, registered decoded outputs and the idle timeout counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q       <= RUN;
      MODE_STATE <= 2'd0;
      SET_HOUR   <= 1'b0;
      SET_MIN    <= 1'b0;
      SET_SEC    <= 1'b0;
      INCR       <= 1'b0;
      tmo_q      <= '0;
    end else begin
      st_q       <= st_d;
      MODE_STATE <= st_d;
      SET_HOUR   <= (st_d == S_HOUR);
      SET_MIN    <= (st_d == S_MIN);
      SET_SEC    <= (st_d == S_SEC);
      INCR       <= incr_d;
      if (!TMO_EN || st_d == RUN || st_d != st_q || incr_d)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + TW'(1);
    end
  end

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RDL = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPL = RW'(REPEAT_PERIOD - 1);

  logic          rep_act_q;
  logic          rep_first_q;
  logic [RW-1:0] rep_q;

  assign rep_tick = rep_act_q & lvl_q[1] &
                    (rep_q == (rep_first_q ? RDL : RPL));

  // Repeat timer armed by an accepted UP press, dropped on release or exit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_q       <= '0;
    end else if (st_d != st_q || st_d == RUN) begin
      rep_act_q <= 1'b0;
      rep_q     <= '0;
    end else if (up_ev) begin
      rep_act_q   <= 1'b1;
      rep_first_q <= 1'b1;
      rep_q       <= '0;
    end else if (!lvl_q[1]) begin
      rep_act_q <= 1'b0;
      rep_q     <= '0;
    end else if (rep_tick) begin
      rep_first_q <= 1'b0;
      rep_q       <= '0;
    end else if (rep_act_q) begin
      rep_q <= rep_q + RW'(1);
    end
  end
`else
  assign rep_tick = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ui.sv
// Directed bench for clock_set_ui.
// Debounce 4, timeout 50, repeat delay 20, period 5.
`timescale 1ns/1ps

module tb_clock_set_ui;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       set_hour;
  logic       set_min;
  logic       set_sec;
  logic       incr;
  logic [1:0] mode_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int incr_cnt = 0;
  int wide_cnt = 0;
  logic incr_prev = 1'b0;
  int incr_q[$];

  always #5 clk = ~clk;

  clock_set_ui #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (50)
`ifdef CLOCK_SET_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
`endif
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .BTN_MODE  (btn_mode),
    .BTN_UP    (btn_up),
    .SET_HOUR  (set_hour),
    .SET_MIN   (set_min),
    .SET_SEC   (set_sec),
    .INCR      (incr),
    .MODE_STATE(mode_state)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    incr_prev <= incr;
    if (incr) begin
      incr_cnt <= incr_cnt + 1;
      incr_q.push_back(cyc);
      if (incr_prev) wide_cnt <= wide_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Event lands on the 7th edge after the raw change.
  task automatic press(input bit up, input int hold);
    if (up) btn_up = 1'b1;
    else    btn_mode = 1'b1;
    tick(hold);
    btn_up   = 1'b0;
    btn_mode = 1'b0;
    tick(8);
  endtask

  task automatic test_reset();
    #7;
    tests++;
    if ({set_hour, set_min, set_sec, incr} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outs: got %b want 0000",
               {set_hour, set_min, set_sec, incr});
    end
    tests++;
    if (mode_state !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: got %0d want 0", mode_state);
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      btn_mode = (i % 2 == 0);
      tick(2);
    end
    btn_mode = 1'b1;
    tick(10);
    tests++;
    if (mode_state !== 2'd1) begin
      fails++;
      $display("FAIL bounce_state: got %0d want 1", mode_state);
    end
    tests++;
    if (set_hour !== 1'b1) begin
      fails++;
      $display("FAIL bounce_hour: got %b want 1", set_hour);
    end
    btn_mode = 1'b0;
    tick(8);
    tests++;
    if (mode_state !== 2'd1) begin
      fails++;
      $display("FAIL bounce_single: got %0d want 1", mode_state);
    end
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_st [4];
    logic [2:0] exp_set [4];
    int base;
    exp_st  = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_set = '{3'b100, 3'b010, 3'b001, 3'b000};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 8);
      tests++;
      if (mode_state !== exp_st[i]) begin
        fails++;
        $display("FAIL cycle_state%0d: got %0d want %0d",
                 i, mode_state, exp_st[i]);
      end
      tests++;
      if ({set_hour, set_min, set_sec} !== exp_set[i]) begin
        fails++;
        $display("FAIL cycle_set%0d: got %b want %b",
                 i, {set_hour, set_min, set_sec}, exp_set[i]);
      end
    end
    base = incr_cnt;
    press(1'b1, 10);
    tests++;
    if (incr_cnt - base !== 0) begin
      fails++;
      $display("FAIL run_up_incr: got %0d pulses want 0",
               incr_cnt - base);
    end
    tests++;
    if (mode_state !== 2'd0) begin
      fails++;
      $display("FAIL run_up_state: got %0d want 0", mode_state);
    end
  endtask

`ifndef CLOCK_SET_AUTOREPEAT_EN
  task automatic test_single_incr();
    int base;
    int wbase;
    int drop;
    apply_reset();
    press(1'b0, 8);
    press(1'b0, 8);
    base  = incr_cnt;
    wbase = wide_cnt;
    drop  = 0;
    btn_up = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (set_min !== 1'b1) drop++;
    end
    btn_up = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (set_min !== 1'b1) drop++;
    end
    tests++;
    if (incr_cnt - base !== 1) begin
      fails++;
      $display("FAIL single_count: got %0d want 1", incr_cnt - base);
    end
    tests++;
    if (wide_cnt - wbase !== 0) begin
      fails++;
      $display("FAIL single_width: got %0d extra cycles want 0",
               wide_cnt - wbase);
    end
    tests++;
    if (drop !== 0) begin
      fails++;
      $display("FAIL single_setmin: got %0d low cycles want 0", drop);
    end
  endtask
`endif

  task automatic test_timeout();
    apply_reset();
    btn_mode = 1'b1;
    tick(7);
    btn_mode = 1'b0;
    tests++;
    if (mode_state !== 2'd1) begin
      fails++;
      $display("FAIL tmo_enter: got %0d want 1", mode_state);
    end
    tick(49);
    tests++;
    if (mode_state !== 2'd1) begin
      fails++;
      $display("FAIL tmo_49: got %0d want 1", mode_state);
    end
    tick(1);
    tests++;
    if (mode_state !== 2'd0) begin
      fails++;
      $display("FAIL tmo_50: got %0d want 0", mode_state);
    end

    apply_reset();
    btn_mode = 1'b1;
    tick(7);
    btn_mode = 1'b0;
    tick(23);
    btn_up = 1'b1;
    tick(7);
    btn_up = 1'b0;
    tests++;
    if (incr !== 1'b1) begin
      fails++;
      $display("FAIL tmo_up30: got %b want 1", incr);
    end
    tick(49);
    tests++;
    if (mode_state !== 2'd1) begin
      fails++;
      $display("FAIL tmo_79: got %0d want 1", mode_state);
    end
    tick(1);
    tests++;
    if (mode_state !== 2'd0) begin
      fails++;
      $display("FAIL tmo_80: got %0d want 0", mode_state);
    end
  endtask

  task automatic test_priority();
    int base;
    apply_reset();
    press(1'b0, 8);
    base = incr_cnt;
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    tick(7);
    tests++;
    if (mode_state !== 2'd2 || incr !== 1'b0) begin
      fails++;
      $display("FAIL prio_edge: got st=%0d incr=%b want st=2 incr=0",
               mode_state, incr);
    end
    tick(3);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    tick(8);
    tests++;
    if (incr_cnt - base !== 0) begin
      fails++;
      $display("FAIL prio_incr: got %0d pulses want 0", incr_cnt - base);
    end
    tests++;
    if (mode_state !== 2'd2) begin
      fails++;
      $display("FAIL prio_state: got %0d want 2", mode_state);
    end
  endtask

  task automatic test_async_reset();
    int base;
    apply_reset();
    press(1'b0, 8);
    press(1'b0, 8);
    tests++;
    if (mode_state !== 2'd2 || set_min !== 1'b1) begin
      fails++;
      $display("FAIL ares_pre: got st=%0d min=%b want st=2 min=1",
               mode_state, set_min);
    end
    base = incr_cnt;
    btn_up = 1'b1;
    tick(10);
    tests++;
    if (incr_cnt - base !== 1) begin
      fails++;
      $display("FAIL ares_up: got %0d pulses want 1", incr_cnt - base);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({set_hour, set_min, set_sec, incr, mode_state} !== 6'd0) begin
      fails++;
      $display("FAIL ares_async: got %b want 000000",
               {set_hour, set_min, set_sec, incr, mode_state});
    end
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    base = incr_cnt;
    tick(20);
    tests++;
    if (incr_cnt - base !== 0 || mode_state !== 2'd0) begin
      fails++;
      $display("FAIL ares_after: got incr=%0d st=%0d want 0 0",
               incr_cnt - base, mode_state);
    end
    btn_up = 1'b0;
    tick(8);
  endtask

`ifdef CLOCK_SET_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int qb;
    int p;
    int offs [6];
    offs = '{0, 20, 25, 30, 35, 40};
    apply_reset();
    press(1'b0, 8);
    press(1'b0, 8);
    press(1'b0, 8);
    tests++;
    if (mode_state !== 2'd3) begin
      fails++;
      $display("FAIL rep_enter: got %0d want 3", mode_state);
    end
    qb = incr_q.size();
    btn_up = 1'b1;
    tick(7);
    p = cyc;
    tick(35);
    btn_up = 1'b0;
    tick(25);
    tests++;
    if (incr_q.size() - qb !== 6) begin
      fails++;
      $display("FAIL rep_count: got %0d want 6", incr_q.size() - qb);
    end else begin
      for (int k = 0; k < 6; k++) begin
        tests++;
        if (incr_q[qb + k] - p !== offs[k]) begin
          fails++;
          $display("FAIL rep_off%0d: got %0d want %0d",
                   k, incr_q[qb + k] - p, offs[k]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bounce();
    test_mode_cycle();
`ifndef CLOCK_SET_AUTOREPEAT_EN
    test_single_incr();
`endif
    test_timeout();
    test_priority();
    test_async_reset();
`ifdef CLOCK_SET_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
